// File: rtl/interrupt_service_control_if.sv
// Bundles the request, acknowledge, EOI and vector signals of interrupt_service_control.
// The master side drives requests and commands; the slave side is the service controller.
interface interrupt_service_control_if #(
    parameter int VECTOR_BASE_W = 5
);
    logic [7:0]               interrupt_request_reg;
    logic [7:0]               interrupt_mask;
    logic                     inta_n;
    logic                     eoi_valid;
    logic                     eoi_specific;
    logic [2:0]               eoi_level;
    logic                     auto_eoi;
    logic [VECTOR_BASE_W-1:0] vector_base;
    logic                     int_out;
    logic [7:0]               clear_irr;
    logic [7:0]               in_service_reg;
    logic [VECTOR_BASE_W+2:0] vector_out;
    logic                     vector_valid;

    modport master (
        output interrupt_request_reg, interrupt_mask, inta_n, eoi_valid,
               eoi_specific, eoi_level, auto_eoi, vector_base,
        input  int_out, clear_irr, in_service_reg, vector_out, vector_valid
    );

    modport slave (
        input  interrupt_request_reg, interrupt_mask, inta_n, eoi_valid,
               eoi_specific, eoi_level, auto_eoi, vector_base,
        output int_out, clear_irr, in_service_reg, vector_out, vector_valid
    );
endinterface

// File: rtl/interrupt_service_control.sv
// Priority resolution against the ISR, two-pulse INTA handshake, ISR/EOI handling and vector issue.
// Optional macro ROTATE_PRIORITY_EN enables rotating priority via a lowest-priority pointer.
module interrupt_service_control #(
    parameter int NUM_IRQ       = 8,
    parameter int VECTOR_BASE_W = 5
) (
    input logic                        clk,
    input logic                        rst_n,
    interrupt_service_control_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t                   r_state;
    logic                     r_intaD;
    logic                     r_intOut;
    logic                     r_vectorValid;
    logic [7:0]               r_isr;
    logic [7:0]               r_clearIrr;
    logic [VECTOR_BASE_W+2:0] r_vectorOut;
    logic [2:0]               r_level;

    logic [7:0] w_eligible;
    logic [7:0] w_eoiMask;
    logic [7:0] w_autoMask;
    logic [7:0] w_setMask;
    logic [7:0] w_isrNext;
    logic       w_fall;
    logic       w_rise;
    logic       w_winValid;
    logic       w_isrAny;
    logic       w_setIsr;
    logic       w_autoClr;
    logic [2:0] w_winLvl;
    logic [2:0] w_isrTopLvl;
    logic [2:0] w_lowPtr;

`ifdef ROTATE_PRIORITY_EN
    logic [2:0] r_ptr;
    logic       w_nsEoi;
    assign w_lowPtr = r_ptr;
    assign w_nsEoi  = bus.eoi_valid && !bus.eoi_specific && w_isrAny;
`else
    assign w_lowPtr = 3'd7;
`endif

    assign w_eligible = bus.interrupt_request_reg & ~bus.interrupt_mask;
    assign w_fall     = r_intaD & ~bus.inta_n;
    assign w_rise     = ~r_intaD & bus.inta_n;

    // Scan from highest to lowest priority; an in-service level blocks itself and everything below it.
    always_comb begin
        logic [2:0] lvl;
        lvl         = '0;
        w_winValid  = 1'b0;
        w_winLvl    = 3'd7;
        w_isrAny    = 1'b0;
        w_isrTopLvl = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            lvl = w_lowPtr + 3'd1 + 3'(i);
            if (!w_isrAny && r_isr[lvl]) begin
                w_isrAny    = 1'b1;
                w_isrTopLvl = lvl;
            end
            if (!w_isrAny && !w_winValid && w_eligible[lvl]) begin
                w_winValid = 1'b1;
                w_winLvl   = lvl;
            end
        end
    end

    // EOI clears are taken from the pre-update ISR, so a simultaneous set on the same bit wins.
    always_comb begin
        w_eoiMask  = '0;
        w_setMask  = '0;
        w_autoMask = '0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                w_eoiMask[bus.eoi_level] = 1'b1;
            end else if (w_isrAny) begin
                w_eoiMask[w_isrTopLvl] = 1'b1;
            end
        end
        w_setIsr = (r_state == REQ) && w_fall && w_winValid;
        if (w_setIsr) begin
            w_setMask[w_winLvl] = 1'b1;
        end
        w_autoClr = (r_state == ACK2) && w_rise && bus.auto_eoi;
        if (w_autoClr) begin
            w_autoMask[r_level] = 1'b1;
        end
        w_isrNext = (r_isr & ~w_eoiMask & ~w_autoMask) | w_setMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_intaD       <= 1'b1;
            r_intOut      <= 1'b0;
            r_vectorValid <= 1'b0;
            r_isr         <= '0;
            r_clearIrr    <= '0;
            r_vectorOut   <= '0;
            r_level       <= '0;
`ifdef ROTATE_PRIORITY_EN
            r_ptr         <= 3'd7;
`endif
        end else begin
            r_intaD       <= bus.inta_n;
            r_isr         <= w_isrNext;
            r_clearIrr    <= '0;
            r_vectorValid <= 1'b0;
`ifdef ROTATE_PRIORITY_EN
            if (w_autoClr) begin
                r_ptr <= r_level;
            end else if (w_nsEoi) begin
                r_ptr <= w_isrTopLvl;
            end
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_winValid) begin
                        r_intOut <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    // A falling edge with no winner is a spurious acknowledge serviced as level 7.
                    if (w_fall) begin
                        r_level    <= w_winValid ? w_winLvl : 3'd7;
                        r_clearIrr <= w_setMask;
                        r_state    <= ACK1;
                    end else if (!w_winValid) begin
                        r_intOut <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                ACK1: begin
                    if (w_rise) begin
                        r_state <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (w_fall) begin
                        r_vectorOut   <= {bus.vector_base, r_level};
                        r_vectorValid <= 1'b1;
                        r_intOut      <= 1'b0;
                        r_state       <= ACK2;
                    end
                end
                ACK2: begin
                    if (w_rise) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.int_out        = r_intOut;
    assign bus.clear_irr      = r_clearIrr;
    assign bus.in_service_reg = r_isr;
    assign bus.vector_out     = r_vectorOut;
    assign bus.vector_valid   = r_vectorValid;
endmodule

// File: tb/tb_interrupt_service_control.sv
// Scoreboard bench for interrupt_service_control: directed stimulus pushes expected ack/vector events,
// a negedge monitor pops and compares them; state checks are done inline.
module tb_interrupt_service_control;
    logic clk;
    logic rst_n;

    interrupt_service_control_if #(.VECTOR_BASE_W(5)) bus ();

    interrupt_service_control #(.NUM_IRQ(8), .VECTOR_BASE_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       isVec;
        logic [7:0] data;
        logic [7:0] isr;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] irr, input logic [7:0] mask);
        bus.interrupt_request_reg = irr;
        bus.interrupt_mask        = mask;
    endtask

    task automatic intaPulse();
        bus.inta_n = 1'b0;
        tick(2);
        bus.inta_n = 1'b1;
        tick(2);
    endtask

    task automatic sendEoi(input logic specific, input logic [2:0] lvl);
        bus.eoi_valid    = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = lvl;
        tick(1);
        bus.eoi_valid    = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        bus.inta_n = 1'b1;
        bus.eoi_valid = 1'b0;
        applyStimulus(8'h00, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Full two-pulse acknowledge; IRR is dropped after the first pulse as the request stage would.
    task automatic fullAck(input logic [7:0] expClr, input logic [7:0] expIsr, input logic [7:0] expVec);
        exp_t e;
        if (expClr != 8'h00) begin
            e.isVec = 1'b0; e.data = expClr; e.isr = expIsr;
            sbQ.push_back(e);
        end
        intaPulse();
        bus.interrupt_request_reg = 8'h00;
        checkOutput("isr_after_first_inta", bus.in_service_reg, expIsr);
        e.isVec = 1'b1; e.data = expVec; e.isr = 8'h00;
        sbQ.push_back(e);
        intaPulse();
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.clear_irr != 8'h00 || bus.vector_valid)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: clear_irr=0x%02h vector_valid=%b, expected none", bus.clear_irr, bus.vector_valid);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                if (e.isVec) begin
                    checkOutput("vector_valid", {7'd0, bus.vector_valid}, 8'h01);
                    checkOutput("vector_out", bus.vector_out, e.data);
                    checkOutput("int_out_at_vector", {7'd0, bus.int_out}, 8'h00);
                end else begin
                    checkOutput("clear_irr", bus.clear_irr, e.data);
                    checkOutput("isr_at_ack", bus.in_service_reg, e.isr);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        bus.inta_n = 1'b1;
        bus.eoi_valid = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level = 3'd0;
        bus.auto_eoi = 1'b0;
        bus.vector_base = 5'h10;
        applyStimulus(8'h00, 8'h00);
        tick(2);
        checkOutput("reset_int_out", {7'd0, bus.int_out}, 8'h00);
        checkOutput("reset_clear_irr", bus.clear_irr, 8'h00);
        checkOutput("reset_isr", bus.in_service_reg, 8'h00);
        checkOutput("reset_vector_out", bus.vector_out, 8'h00);
        checkOutput("reset_vector_valid", {7'd0, bus.vector_valid}, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // Basic service of level 3
        applyStimulus(8'h08, 8'h00);
        tick(1);
        checkOutput("int_out_rise", {7'd0, bus.int_out}, 8'h01);
        fullAck(8'h08, 8'h08, 8'h83);
        checkOutput("int_out_after_ack", {7'd0, bus.int_out}, 8'h00);
        checkOutput("isr_level3", bus.in_service_reg, 8'h08);

        sendEoi(1'b1, 3'd3);
        checkOutput("isr_specific_eoi3", bus.in_service_reg, 8'h00);
        sendEoi(1'b0, 3'd0);
        checkOutput("isr_nonspecific_empty", bus.in_service_reg, 8'h00);

        // Nesting against ISR=0x04
        applyStimulus(8'h04, 8'h00);
        tick(1);
        fullAck(8'h04, 8'h04, 8'h82);
        applyStimulus(8'h10, 8'h00);
        tick(2);
        checkOutput("lower_blocked", {7'd0, bus.int_out}, 8'h00);
        applyStimulus(8'h02, 8'h00);
        tick(1);
        checkOutput("higher_nests", {7'd0, bus.int_out}, 8'h01);
        fullAck(8'h02, 8'h06, 8'h81);
        checkOutput("isr_nested", bus.in_service_reg, 8'h06);
        sendEoi(1'b0, 3'd0);
        checkOutput("isr_nonspecific", bus.in_service_reg, 8'h04);
        sendEoi(1'b1, 3'd2);
        checkOutput("isr_specific_eoi2", bus.in_service_reg, 8'h00);

        // Masked request never raises INT
        applyStimulus(8'h08, 8'h08);
        tick(2);
        checkOutput("masked", {7'd0, bus.int_out}, 8'h00);
        applyStimulus(8'h00, 8'h00);
        tick(1);

        // Spurious: request vanishes on the same cycle as the first INTA falling edge
        applyStimulus(8'h20, 8'h00);
        tick(1);
        checkOutput("int_out_level5", {7'd0, bus.int_out}, 8'h01);
        bus.interrupt_request_reg = 8'h00;
        intaPulse();
        checkOutput("spurious_isr", bus.in_service_reg, 8'h00);
        checkOutput("spurious_int_held", {7'd0, bus.int_out}, 8'h01);
        e.isVec = 1'b1; e.data = 8'h87; e.isr = 8'h00;
        sbQ.push_back(e);
        intaPulse();
        checkOutput("spurious_int_out", {7'd0, bus.int_out}, 8'h00);

        // Automatic EOI
        bus.auto_eoi = 1'b1;
        applyStimulus(8'h01, 8'h00);
        tick(1);
        fullAck(8'h01, 8'h01, 8'h80);
        checkOutput("auto_eoi_isr", bus.in_service_reg, 8'h00);

        // Reset asserted during ACK1
        applyStimulus(8'h01, 8'h00);
        tick(1);
        e.isVec = 1'b0; e.data = 8'h01; e.isr = 8'h01;
        sbQ.push_back(e);
        bus.inta_n = 1'b0;
        tick(1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.inta_n = 1'b1;
        applyStimulus(8'h00, 8'h00);
        #1;
        checkOutput("midreset_int_out", {7'd0, bus.int_out}, 8'h00);
        checkOutput("midreset_clear_irr", bus.clear_irr, 8'h00);
        checkOutput("midreset_isr", bus.in_service_reg, 8'h00);
        checkOutput("midreset_vector_out", bus.vector_out, 8'h00);
        checkOutput("midreset_vector_valid", {7'd0, bus.vector_valid}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        bus.auto_eoi = 1'b0;
        tick(1);
        applyStimulus(8'h40, 8'h00);
        tick(1);
        checkOutput("post_reset_idle", {7'd0, bus.int_out}, 8'h01);
        fullAck(8'h40, 8'h40, 8'h86);

`ifdef ROTATE_PRIORITY_EN
        applyReset();
        applyStimulus(8'h08, 8'h00);
        tick(1);
        fullAck(8'h08, 8'h08, 8'h83);
        sendEoi(1'b0, 3'd0);
        checkOutput("rot_eoi_isr", bus.in_service_reg, 8'h00);
        applyStimulus(8'h11, 8'h00);
        tick(1);
        checkOutput("rot_int_out", {7'd0, bus.int_out}, 8'h01);
        fullAck(8'h10, 8'h10, 8'h84);
`endif

        tick(4);
        while (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_event: got nothing, expected data 0x%02h (vector=%b)", e.data, e.isVec);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_service_control.md
Name: interrupt_service_control

Overview:
Downstream of the interrupt request register stage. Takes the latched request vector and the mask, and resolves priority against the in-service register (ISR). Asserts INT, runs the two-pulse INTA acknowledge handshake, sets/clears ISR bits, issues the IRR clear pulse and the interrupt vector. Handles non-specific, specific and automatic EOI.

Parameters:
NUM_IRQ, 8, number of request levels; only 8 supported (level index fixed at 3 bits)
VECTOR_BASE_W, 5, width of vector base field (vector = {base, level})

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
interrupt_request_reg  input  8  latched requests from request stage
interrupt_mask  input  8  1 = level masked
inta_n  input  1  acknowledge strobe, active low, already synchronous to clk
eoi_valid  input  1  one-cycle EOI command strobe
eoi_specific  input  1  1 = specific EOI, 0 = non-specific
eoi_level  input  3  target level for specific EOI
auto_eoi  input  1  1 = clear ISR bit at end of second INTA
vector_base  input  VECTOR_BASE_W  upper vector bits
int_out  output  1  interrupt request to CPU
clear_irr  output  8  one-cycle one-hot pulse clearing acknowledged request
in_service_reg  output  8  ISR contents
vector_out  output  8  {vector_base, level}
vector_valid  output  1  one-cycle strobe, vector_out valid

Behaviour:
- Reset (async, rst_n=0): int_out=0, clear_irr=0, in_service_reg=0, vector_out=0, vector_valid=0, FSM=IDLE, inta_n history=1.
- Eligible = interrupt_request_reg & ~interrupt_mask. Priority fixed: level 0 highest.
- Winner = highest-priority eligible level strictly higher than the highest-priority set ISR bit. If no ISR bit is set, any eligible level wins.
- INTA edges: registered inta_n_d. Falling = inta_n_d & ~inta_n; rising = ~inta_n_d & inta_n.
- FSM:
  IDLE: a winner exists -> int_out=1 next cycle, go REQ.
  REQ: a winner no longer exists and no INTA falling edge -> int_out=0, back to IDLE. INTA falling -> latch winner level L, set ISR[L], clear_irr=1<<L for one cycle, go ACK1.
  ACK1: INTA rising -> go WAIT2.
  WAIT2: INTA falling -> vector_out={vector_base,L}, vector_valid=1 for one cycle, int_out=0, go ACK2.
  ACK2: INTA rising -> if auto_eoi, clear ISR[L]; go IDLE.
- Spurious: no winner at first INTA falling edge -> L=7, ISR unchanged, clear_irr=0. The vector still carries level 7.
- Latency: int_out rises 1 cycle after a winner appears. clear_irr and the ISR set occur on the cycle after the INTA falling edge is sampled.
- EOI (any state): non-specific clears the highest-priority set ISR bit (no-op if ISR=0); specific clears ISR[eoi_level].
- EOI and ISR set in the same cycle: the EOI is evaluated on the pre-update ISR, then the set is applied. On the same bit, the set wins.
- INTA falling edge in IDLE/ACK1/ACK2: ignored. Mask change mid-handshake: no effect after L is latched.

Optional Feature:
Macro ROTATE_PRIORITY_EN.
- Defined: a 3-bit lowest-priority pointer P (reset 7). Priority order starts at P+1 mod 8. Each non-specific EOI or auto-EOI clear sets P to the level cleared. Non-specific EOI clears the highest-priority set ISR bit under the current rotation.
- Undefined: no pointer; fixed order, level 0 highest.

Test Plan:
- IRR=0x08, mask=0x00 -> int_out=1 after 1 cycle. First INTA: ISR=0x08, clear_irr=0x08. Second INTA with base=0x10: vector_out=0x83, vector_valid=1.
- ISR=0x04 set, IRR=0x10 -> int_out stays 0. IRR=0x02 -> int_out=1, ack sets ISR=0x06.
- ISR=0x06, non-specific EOI -> ISR=0x04. Specific EOI level 2 -> ISR=0x00.
- IRR=0x20, int_out=1, IRR drops to 0 before INTA, then INTA pair -> ISR=0x00, clear_irr=0, vector level 7.
- auto_eoi=1, IRR=0x01 -> ISR=0x01 after first INTA, ISR=0x00 after second INTA rising edge. Assert rst_n=0 mid-ACK1 -> all outputs 0, FSM IDLE.
- ROTATE_PRIORITY_EN: service level 3, then non-specific EOI -> P=3. With IRR=0x11, level 4 wins over level 0.
